mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 16-word x 16-bit single-clock memory (separate registered read and write ports). Each requester issues single-word read or write commands over a valid/ready handshake. The block drives the memory's `wr_en`/`addrw`/`wdata` and `rd_en`/`addrr` strobes, and routes the registered `rdata` back to the requester that issued the read. It sits between two client engines and the memory instance, so the memory can issue one read and one write in the same cycle. Reads and writes have independent round-robin priority.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a 1R1W registered memory: independent round-robin
// grants for reads and writes, read data routed back to the issuing requester.
module mem_port_arbiter #(
    parameter int AW = 4,
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addrw,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addrr,
    input  logic [DW-1:0] mem_rdata,

    output logic [CW-1:0] contention_cnt
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e rd_prio;
    prio_e wr_prio;
    logic  tag_valid;
    prio_e tag_owner;

    logic rd_conflict, wr_conflict;
    logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;
    prio_e a_type_prio, b_type_prio;

    assign rd_conflict = a_valid & b_valid & ~a_we & ~b_we;
    assign wr_conflict = a_valid & b_valid &  a_we &  b_we;

    // Ready depends only on the other side, so it is valid even when own valid is low.
    always_comb begin
        a_type_prio = a_we ? wr_prio : rd_prio;
        b_type_prio = b_we ? wr_prio : rd_prio;
        a_ready = ~rst & ~(b_valid & (b_we == a_we) & (a_type_prio == PRIO_B));
        b_ready = ~rst & ~(a_valid & (a_we == b_we) & (b_type_prio == PRIO_A));
    end

    assign a_rd_gnt = a_valid & ~a_we & a_ready;
    assign b_rd_gnt = b_valid & ~b_we & b_ready;
    assign a_wr_gnt = a_valid &  a_we & a_ready;
    assign b_wr_gnt = b_valid &  b_we & b_ready;

    always_comb begin
        mem_rd_en = a_rd_gnt | b_rd_gnt;
        mem_addrr = '0;
        if (a_rd_gnt)      mem_addrr = a_addr;
        else if (b_rd_gnt) mem_addrr = b_addr;

        mem_wr_en = a_wr_gnt | b_wr_gnt;
        mem_addrw = '0;
        mem_wdata = '0;
        if (a_wr_gnt) begin
            mem_addrw = a_addr;
            mem_wdata = a_wdata;
        end else if (b_wr_gnt) begin
            mem_addrw = b_addr;
            mem_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_prio        <= PRIO_A;
            wr_prio        <= PRIO_A;
            tag_valid      <= 1'b0;
            tag_owner      <= PRIO_A;
            contention_cnt <= '0;
        end else begin
            // On a collision the pointer moves to the requester that just lost.
            if (rd_conflict) rd_prio <= (rd_prio == PRIO_A) ? PRIO_B : PRIO_A;
            if (wr_conflict) wr_prio <= (wr_prio == PRIO_A) ? PRIO_B : PRIO_A;
            tag_valid <= a_rd_gnt | b_rd_gnt;
            tag_owner <= b_rd_gnt ? PRIO_B : PRIO_A;
            if ((rd_conflict | wr_conflict) && (contention_cnt != '1))
                contention_cnt <= contention_cnt + 1'b1;
        end
    end

    always_comb begin
        a_rvalid = tag_valid & (tag_owner == PRIO_A);
        b_rvalid = tag_valid & (tag_owner == PRIO_B);
        a_rdata  = a_rvalid ? mem_rdata : '0;
        b_rdata  = b_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural arbitration/memory model
// queues expected read responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addrw, mem_addrr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] contention_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_wr_en(mem_wr_en), .mem_addrw(mem_addrw), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_addrr(mem_addrr), .mem_rdata(mem_rdata),
        .contention_cnt(contention_cnt)
    );

    // Memory instance the arbiter drives: registered read, read-before-write.
    logic [DW-1:0] mem_arr [16];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_arr[mem_addrr];
        if (mem_wr_en) mem_arr[mem_addrw] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t qa[$];
    rsp_t qb[$];

    logic [DW-1:0] ref_mem [16];
    bit m_rprio, m_wprio;
    int m_cnt;
    bit a_acc, b_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rprio = 1'b0;
        m_wprio = 1'b0;
        m_cnt   = 0;
        qa.delete();
        qb.delete();
        a_acc = 1'b0;
        b_acc = 1'b0;
    endtask

    // Reference: per op type, the set of contenders decides the winner.
    task automatic model_cycle();
        bit exp_a, exp_b, contended, ca, cb, p;
        bit exp_rd, exp_wr;
        logic [AW-1:0] raddr, waddr;
        logic [DW-1:0] wdat;
        exp_a = 1'b0; exp_b = 1'b0; contended = 1'b0;
        for (int t = 0; t < 2; t++) begin
            ca = a_valid && (a_we == t[0]);
            cb = b_valid && (b_we == t[0]);
            p  = (t == 1) ? m_wprio : m_rprio;
            if (ca && cb) begin
                contended = 1'b1;
                if (p == 1'b0) exp_a = 1'b1; else exp_b = 1'b1;
                if (t == 1) m_wprio = ~m_wprio; else m_rprio = ~m_rprio;
            end else begin
                if (ca) exp_a = 1'b1;
                if (cb) exp_b = 1'b1;
            end
        end

        chk("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
        if (a_valid) chk("a_ready", 32'(a_ready), 32'(exp_a));
        if (b_valid) chk("b_ready", 32'(b_ready), 32'(exp_b));

        exp_rd = (exp_a && !a_we) || (exp_b && !b_we);
        exp_wr = (exp_a && a_we) || (exp_b && b_we);
        raddr  = (exp_a && !a_we) ? a_addr : (exp_b && !b_we) ? b_addr : '0;
        waddr  = (exp_a && a_we) ? a_addr : (exp_b && b_we) ? b_addr : '0;
        wdat   = (exp_a && a_we) ? a_wdata : (exp_b && b_we) ? b_wdata : '0;
        chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
        chk("mem_addrr", 32'(mem_addrr), 32'(raddr));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
        chk("mem_addrw", 32'(mem_addrw), 32'(waddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(wdat));

        if (exp_a && !a_we) qa.push_back('{due: cyc + 1, data: ref_mem[a_addr]});
        if (exp_b && !b_we) qb.push_back('{due: cyc + 1, data: ref_mem[b_addr]});
        if (exp_wr) ref_mem[waddr] = wdat;
        if (contended && m_cnt < CNT_MAX) m_cnt++;
        a_acc = exp_a;
        b_acc = exp_b;
    endtask

    task automatic step(input logic av, input logic awe, input logic [AW-1:0] aad,
                        input logic [DW-1:0] awd, input logic bv, input logic bwe,
                        input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        @(posedge clk);
        #1;
        a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
        b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                chk("a_rvalid", 32'(a_rvalid), 32'd1);
                chk("a_rdata", 32'(a_rdata), 32'(qa[0].data));
                void'(qa.pop_front());
            end else begin
                chk("a_rvalid_idle", 32'(a_rvalid), 32'd0);
                chk("a_rdata_idle", 32'(a_rdata), 32'd0);
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                chk("b_rvalid", 32'(b_rvalid), 32'd1);
                chk("b_rdata", 32'(b_rdata), 32'(qb[0].data));
                void'(qb.pop_front());
            end else begin
                chk("b_rvalid_idle", 32'(b_rvalid), 32'd0);
                chk("b_rdata_idle", 32'(b_rdata), 32'd0);
            end
        end
    end

    logic          pav, pawe, pbv, pbwe;
    logic [AW-1:0] paad, pbad;
    logic [DW-1:0] pawd, pbwd;

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b1; b_we = 1'b1; b_addr = '0; b_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_cnt", 32'(contention_cnt), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, AW'(i), DW'(i * 257) ^ 16'h5A5A, 1'b0, 1'b0, '0, '0);
        idle();

        // write then read back on requester a
        step(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // read contention alternates a, b, a, b
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
            chk("alt_a_ready", 32'(a_ready), 32'((i % 2) == 0));
            chk("alt_b_ready", 32'(b_ready), 32'((i % 2) == 1));
        end
        idle();
        chk("cnt_after_4", 32'(contention_cnt), 32'd4);
        idle();

        // same-address write and read in one cycle
        step(1'b1, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 4'd5, '0);
        chk("rw_a_ready", 32'(a_ready), 32'd1);
        chk("rw_b_ready", 32'(b_ready), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, '0);
        idle();
        idle();

        // write collision: a first, then held b
        step(1'b1, 1'b1, 4'd0, 16'h0A0A, 1'b1, 1'b1, 4'd0, 16'h0B0B);
        chk("ww_b_ready_first", 32'(b_ready), 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd0, 16'h0B0B);
        chk("ww_b_ready_second", 32'(b_ready), 32'd1);
        step(1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // reset pulse while a read response is pending
        step(1'b1, 1'b0, 4'd7, '0, 1'b1, 1'b0, 4'd8, '0);
        @(posedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstpulse_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rstpulse_a_rdata", 32'(a_rdata), 32'd0);
        chk("rstpulse_cnt", 32'(contention_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        step(1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
        chk("post_rst_a_wins", 32'(a_ready), 32'd1);
        idle();

        // randomized traffic, losers hold their command
        pav = 1'b0; pbv = 1'b0;
        pawe = 1'b0; pbwe = 1'b0; paad = '0; pbad = '0; pawd = '0; pbwd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(pav && !a_acc)) begin
                pav  = ($urandom_range(3) != 0);
                pawe = 1'($urandom_range(1));
                paad = AW'($urandom_range(15));
                pawd = DW'($urandom);
            end
            if (!(pbv && !b_acc)) begin
                pbv  = ($urandom_range(3) != 0);
                pbwe = 1'($urandom_range(1));
                pbad = AW'($urandom_range(15));
                pbwd = DW'($urandom);
            end
            step(pav, pawe, paad, pawd, pbv, pbwe, pbad, pbwd);
        end
        idle();

        // counter saturation under sustained read contention
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 1), '0);
        idle();
        chk("cnt_saturated", 32'(contention_cnt), 32'(CNT_MAX));
        idle();
        idle();
        chk("queues_drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
